// File: rtl/johnson_dec_pkg.sv
// rtl/johnson_dec_pkg.sv - shared types and constants for the Johnson decoder
package johnson_dec_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } jd_state_e;

   localparam int              ERR_W   = 8;
   localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};
   localparam int              RUN_W   = 4;

endpackage

// File: rtl/johnson_index.sv
// rtl/johnson_index.sv - combinational Johnson code legality check and index decode
module johnson_index #(
   parameter int N  = 4,
   parameter int IW = $clog2(2*N)
) (
   input  logic [N-1:0]  q,
   output logic          legal,
   output logic [IW-1:0] index
);

   logic [IW:0] trans;
   logic [IW:0] pop;
   logic [IW:0] idx_full;

   always_comb begin
      trans = '0;
      pop   = '0;
      for (int i = 0; i < N - 1; i++) begin
         trans = trans + {{IW{1'b0}}, q[i] ^ q[i+1]};
      end
      for (int i = 0; i < N; i++) begin
         pop = pop + {{IW{1'b0}}, q[i]};
      end
      legal = (trans < (IW+1)'(2));
      // Codes with the top bit clear (other than zero) sit in the draining half of the ring
      if (q[N-1] || (q == '0)) begin
         idx_full = pop;
      end else begin
         idx_full = (IW+1)'(2*N) - pop;
      end
      index = idx_full[IW-1:0];
   end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with lock tracking and error flags
// Optional saturating error counter built when JOHNSON_DECODER_ERRCNT_EN is defined.
module johnson_decoder
   import johnson_dec_pkg::*;
#(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           q,
   input  logic                   in_valid,
   output logic [$clog2(2*N)-1:0] count,
   output logic                   out_valid,
   output logic                   locked,
   output logic                   code_err,
   output logic                   seq_err,
   output logic [ERR_W-1:0]       err_cnt
);

   localparam int               CW       = $clog2(2*N);
   localparam logic [CW-1:0]    LAST_IDX = CW'(2*N - 1);
   localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);

   jd_state_e        state, state_nxt;
   logic [CW-1:0]    count_nxt;
   logic [RUN_W-1:0] run, run_nxt, run_inc;
   logic             have_prev, have_prev_nxt;
   logic             out_valid_nxt, code_err_nxt, seq_err_nxt;
   logic             legal;
   logic [CW-1:0]    idx;
   logic [CW-1:0]    succ;
   logic             is_succ, is_repeat;

   johnson_index #(
      .N  (N),
      .IW (CW)
   ) u_index (
      .q     (q),
      .legal (legal),
      .index (idx)
   );

   // Wrap is explicit so non-power-of-two ring lengths also close correctly
   assign succ      = (count == LAST_IDX) ? '0 : count + CW'(1);
   assign is_succ   = have_prev && (idx == succ);
   assign is_repeat = have_prev && (idx == count);
   assign run_inc   = run + RUN_W'(1);

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      run_nxt       = run;
      have_prev_nxt = have_prev;
      out_valid_nxt = 1'b0;
      code_err_nxt  = 1'b0;
      seq_err_nxt   = 1'b0;
      if (in_valid) begin
         if (!legal) begin
            code_err_nxt = 1'b1;
            run_nxt      = '0;
            state_nxt    = UNLOCKED;
         end else begin
            count_nxt     = idx;
            out_valid_nxt = 1'b1;
            have_prev_nxt = 1'b1;
            case (state)
               UNLOCKED: begin
                  if (is_succ) begin
                     run_nxt = run_inc;
                     if (run_inc >= LOCK_TGT) begin
                        state_nxt = LOCKED;
                     end
                  end else begin
                     run_nxt = '0;
                  end
               end
               LOCKED: begin
                  if (!is_succ && !is_repeat) begin
                     seq_err_nxt = 1'b1;
                     run_nxt     = '0;
                     state_nxt   = UNLOCKED;
                  end
               end
               default: begin
                  run_nxt   = '0;
                  state_nxt = UNLOCKED;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= UNLOCKED;
         count     <= '0;
         run       <= '0;
         have_prev <= 1'b0;
         out_valid <= 1'b0;
         code_err  <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         run       <= run_nxt;
         have_prev <= have_prev_nxt;
         out_valid <= out_valid_nxt;
         code_err  <= code_err_nxt;
         seq_err   <= seq_err_nxt;
      end
   end

   assign locked = (state == LOCKED);

`ifdef JOHNSON_DECODER_ERRCNT_EN
   logic [ERR_W-1:0] err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= '0;
      end else if ((code_err_nxt || seq_err_nxt) && (err_q != ERR_SAT)) begin
         err_q <= err_q + ERR_W'(1);
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - directed self-checking bench for johnson_decoder (N=4, LOCK_CNT=3)
module tb_johnson_decoder;

`ifdef JOHNSON_DECODER_ERRCNT_EN
   localparam bit ERRCNT_ON = 1'b1;
`else
   localparam bit ERRCNT_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] q;
   logic       in_valid;
   logic [2:0] count;
   logic       out_valid;
   logic       locked;
   logic       code_err;
   logic       seq_err;
   logic [7:0] err_cnt;

   int checks;
   int errors;

   johnson_decoder #(
      .N        (4),
      .LOCK_CNT (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .q         (q),
      .in_valid  (in_valid),
      .count     (count),
      .out_valid (out_valid),
      .locked    (locked),
      .code_err  (code_err),
      .seq_err   (seq_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_err(input int n);
      return ERRCNT_ON ? 8'(n) : 8'd0;
   endfunction

   task automatic sample(input logic [3:0] v);
      @(negedge clk);
      q        = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; q = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({count, out_valid, locked, code_err, seq_err} !== 7'd0) begin
         errors++;
         $display("FAIL reset_outputs: got count=%0d ov=%0b lk=%0b ce=%0b se=%0b, want all 0", count, out_valid, locked, code_err, seq_err);
      end
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lock();
      logic [3:0] seq [4];
      seq = '{4'b0000, 4'b1000, 4'b1100, 4'b1110};
      for (int i = 0; i < 4; i++) begin
         sample(seq[i]);
         checks++;
         if (count !== 3'(i) || out_valid !== 1'b1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL lock_step%0d: got count=%0d ov=%0b se=%0b, want count=%0d ov=1 se=0", i, count, out_valid, seq_err, i);
         end
         checks++;
         if (locked !== (i == 3)) begin
            errors++;
            $display("FAIL lock_flag%0d: got %0b want %0b", i, locked, (i == 3));
         end
      end
   endtask

   task automatic test_idle_and_repeat();
      idle();
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd3 || locked !== 1'b1) begin
         errors++;
         $display("FAIL idle_hold: got ov=%0b count=%0d lk=%0b, want ov=0 count=3 lk=1", out_valid, count, locked);
      end
      sample(4'b1110);
      checks++;
      if (out_valid !== 1'b1 || count !== 3'd3 || locked !== 1'b1 || seq_err !== 1'b0 || code_err !== 1'b0) begin
         errors++;
         $display("FAIL locked_repeat: got ov=%0b count=%0d lk=%0b se=%0b ce=%0b, want 1/3/1/0/0", out_valid, count, locked, seq_err, code_err);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] seq [7];
      logic [2:0] exp [7];
      seq = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100};
      exp = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
      for (int i = 0; i < 7; i++) begin
         sample(seq[i]);
         checks++;
         if (count !== exp[i] || locked !== 1'b1 || seq_err !== 1'b0 || code_err !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_step%0d: got count=%0d lk=%0b se=%0b ce=%0b ov=%0b, want count=%0d lk=1 se=0 ce=0 ov=1", i, count, locked, seq_err, code_err, out_valid, exp[i]);
         end
      end
   endtask

   task automatic test_code_err();
      sample(4'b1010);
      checks++;
      if (code_err !== 1'b1 || count !== 3'd2 || locked !== 1'b0 || out_valid !== 1'b0 || seq_err !== 1'b0) begin
         errors++;
         $display("FAIL code_err: got ce=%0b count=%0d lk=%0b ov=%0b se=%0b, want 1/2/0/0/0", code_err, count, locked, out_valid, seq_err);
      end
      checks++;
      if (err_cnt !== exp_err(1)) begin
         errors++;
         $display("FAIL code_err_cnt: got %0d want %0d", err_cnt, exp_err(1));
      end
      idle();
      checks++;
      if (code_err !== 1'b0) begin
         errors++;
         $display("FAIL code_err_pulse: got %0b want 0", code_err);
      end
   endtask

   task automatic test_seq_err();
      sample(4'b0000);
      checks++;
      if (seq_err !== 1'b0 || count !== 3'd0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL unlocked_nonsucc: got se=%0b count=%0d lk=%0b, want 0/0/0", seq_err, count, locked);
      end
      sample(4'b1000);
      sample(4'b1100);
      sample(4'b1110);
      checks++;
      if (locked !== 1'b1 || count !== 3'd3) begin
         errors++;
         $display("FAIL relock: got lk=%0b count=%0d, want 1/3", locked, count);
      end
      sample(4'b0011);
      checks++;
      if (seq_err !== 1'b1 || count !== 3'd6 || locked !== 1'b0 || code_err !== 1'b0) begin
         errors++;
         $display("FAIL seq_err: got se=%0b count=%0d lk=%0b ce=%0b, want 1/6/0/0", seq_err, count, locked, code_err);
      end
      checks++;
      if (err_cnt !== exp_err(2)) begin
         errors++;
         $display("FAIL seq_err_cnt: got %0d want %0d", err_cnt, exp_err(2));
      end
   endtask

   task automatic test_reset_mid_run();
      sample(4'b1010);
      sample(4'b0101);
      sample(4'b1001);
      sample(4'b0000);
      sample(4'b1000);
      sample(4'b1100);
      sample(4'b1110);
      checks++;
      if (locked !== 1'b1 || err_cnt !== exp_err(5)) begin
         errors++;
         $display("FAIL pre_reset: got lk=%0b err_cnt=%0d, want 1/%0d", locked, err_cnt, exp_err(5));
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({count, out_valid, locked, code_err, seq_err} !== 7'd0 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got count=%0d ov=%0b lk=%0b ce=%0b se=%0b err_cnt=%0d, want all 0", count, out_valid, locked, code_err, seq_err, err_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sample(4'b0111);
      checks++;
      if (seq_err !== 1'b0 || out_valid !== 1'b1 || count !== 3'd5 || locked !== 1'b0) begin
         errors++;
         $display("FAIL first_after_reset: got se=%0b ov=%0b count=%0d lk=%0b, want 0/1/5/0", seq_err, out_valid, count, locked);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 260; i++) begin
         sample(4'b1010);
         if (i == 254) begin
            checks++;
            if (err_cnt !== exp_err(255)) begin
               errors++;
               $display("FAIL sat_reach: got %0d want %0d", err_cnt, exp_err(255));
            end
         end
      end
      checks++;
      if (err_cnt !== exp_err(255) || code_err !== 1'b1 || count !== 3'd5) begin
         errors++;
         $display("FAIL sat_hold: got err_cnt=%0d ce=%0b count=%0d, want %0d/1/5", err_cnt, code_err, count, exp_err(255));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_lock();
      test_idle_and_repeat();
      test_wrap();
      test_code_err();
      test_seq_err();
      test_reset_mid_run();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
